// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache and the fetch stage:
// line geometry, controller states, reset PC and address field helpers.
package icache_pkg;

    localparam int LINE_BYTES     = 16;
    localparam int WORDS_PER_LINE = 4;

    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    typedef enum logic {
        LOOKUP = 1'b0,
        WAIT   = 1'b1
    } state_t;

    // Line index sits directly above the 4-bit byte offset.
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int iw);
        return (addr >> 4) & ((32'd1 << iw) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int iw);
        return addr >> (4 + iw);
    endfunction

    function automatic logic [1:0] addr_word(input logic [31:0] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/m_icache_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read,
// one synchronous line write, synchronous invalidate-all, async valid clear.
module m_icache_array
    import icache_pkg::*;
#(
    parameter int LINES = 4,
    parameter int IW    = $clog2(LINES),
    parameter int TAG_W = 28 - IW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [IW-1:0]             rd_index,
    output logic                      rd_valid,
    output logic [TAG_W-1:0]          rd_tag,
    output logic [LINE_BYTES*8-1:0]   rd_data,
    input  logic                      wr_en,
    input  logic [IW-1:0]             wr_index,
    input  logic [TAG_W-1:0]          wr_tag,
    input  logic [LINE_BYTES*8-1:0]   wr_data,
    input  logic                      inv_all
);

    localparam int LINE_W = LINE_BYTES * 8;

    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [TAG_W-1:0]  tag_d  [LINES];
    logic [LINE_W-1:0] data_q [LINES];
    logic [LINE_W-1:0] data_d [LINES];

    // Invalidate-all wins over a same-cycle install.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_index] = 1'b1;
            tag_d[wr_index]   = wr_tag;
            data_d[wr_index]  = wr_data;
        end
        if (inv_all) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/m_icache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, single
// outstanding line refill over a req/ack handshake, flush with drop.
module m_icache
    import icache_pkg::*;
#(
    parameter int LINES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  pc_in,
    input  logic         flush,
    output logic [31:0]  instr,
    output logic         instr_valid,
    output logic         stall,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_ack,
    input  logic [127:0] mem_rdata
);

    localparam int IW    = $clog2(LINES);
    localparam int TAG_W = 28 - IW;

    state_t             state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic               drop_q, drop_d;

    logic [IW-1:0]      pc_index, wr_index;
    logic [TAG_W-1:0]   pc_tag, wr_tag;
    logic [1:0]         pc_word;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [127:0]       rd_data;
    logic               wr_en;
    logic               hit;

    assign pc_index = IW'(addr_index(pc_in, IW));
    assign pc_tag   = TAG_W'(addr_tag(pc_in, IW));
    assign pc_word  = addr_word(pc_in);

    // Refill lands at the latched miss address, never the live PC.
    assign wr_index = IW'(addr_index(mem_addr_q, IW));
    assign wr_tag   = TAG_W'(addr_tag(mem_addr_q, IW));

    assign hit = (state_q == LOOKUP) && !flush && rd_valid && (rd_tag == pc_tag);

    m_icache_array #(
        .LINES (LINES),
        .IW    (IW),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_index (pc_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_tag   (wr_tag),
        .wr_data  (mem_rdata),
        .inv_all  (flush)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        drop_d      = drop_q;
        wr_en       = 1'b0;
        instr_valid = hit;
        stall       = !hit;
        instr       = hit ? rd_data[{pc_word, 5'b0} +: 32] : 32'h0;

        case (state_q)
            LOOKUP: begin
                if (!flush && !hit) begin
                    mem_addr_d = {pc_in[31:4], 4'b0000};
                    mem_req_d  = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // A flush seen during or with the ack discards the returning line.
                if (mem_ack) begin
                    wr_en     = !drop_q && !flush;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    state_d   = LOOKUP;
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = LOOKUP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LOOKUP;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            drop_q     <= drop_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_m_icache.sv
// Directed bench for m_icache: a line-level cache model checked every cycle,
// plus literal expectations for miss penalty, refill addresses and data.
module tb_m_icache;

    localparam int LINES = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  pc_in;
    logic         flush;
    logic [31:0]  instr;
    logic         instr_valid;
    logic         stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [127:0] mem_rdata;

    int compared = 0;
    int failed   = 0;

    always #5 clk = ~clk;

    m_icache #(.LINES(LINES)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    // Memory image: line 0x1000 carries the recognisable 1111..4444 pattern.
    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        if (a == 32'h0000_1000) begin
            l = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        end else begin
            for (int w = 0; w < 4; w++) begin
                l[32*w +: 32] = {8'hAB, a[23:0]} + 32'(4 * w);
            end
        end
        return l;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: each slot remembers which memory line it holds; one pending refill.
    logic         m_valid [LINES];
    logic [27:0]  m_line  [LINES];
    logic [127:0] m_data  [LINES];
    logic         m_pend;
    logic         m_drop;
    logic [31:0]  m_addr;

    function automatic int slot_of(input logic [31:0] a);
        return int'((a >> 4) % LINES);
    endfunction

    function automatic logic m_hit();
        int s;
        s = slot_of(pc_in);
        return !m_pend && !flush && m_valid[s] && (m_line[s] == pc_in[31:4]);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) m_valid[i] <= 1'b0;
            m_pend <= 1'b0;
            m_drop <= 1'b0;
            m_addr <= 32'h0;
        end else begin
            if (flush) begin
                for (int i = 0; i < LINES; i++) m_valid[i] <= 1'b0;
            end
            if (m_pend) begin
                if (mem_ack) begin
                    if (!m_drop && !flush) begin
                        m_valid[slot_of(m_addr)] <= 1'b1;
                        m_line[slot_of(m_addr)]  <= m_addr[31:4];
                        m_data[slot_of(m_addr)]  <= mem_rdata;
                    end
                    m_pend <= 1'b0;
                    m_drop <= 1'b0;
                end else if (flush) begin
                    m_drop <= 1'b1;
                end
            end else if (!flush && !m_hit()) begin
                m_pend <= 1'b1;
                m_addr <= {pc_in[31:4], 4'b0000};
            end
        end
    end

    always @(negedge clk) begin
        logic         h;
        logic [31:0]  ei;
        h  = m_hit();
        ei = h ? m_data[slot_of(pc_in)][32*int'(pc_in[3:2]) +: 32] : 32'h0;
        check("cyc_instr_valid", 32'(instr_valid), 32'(h));
        check("cyc_stall", 32'(stall), 32'(!h));
        check("cyc_instr", instr, ei);
        check("cyc_mem_req", 32'(mem_req), 32'(m_pend));
        check("cyc_mem_addr", mem_addr, m_addr);
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Acts as memory until the current pc hits: acks the n-th cycle of each request,
    // optionally redirects pc or pulses flush during the first request.
    task automatic serve(input int n, input int redir, input logic [31:0] npc, input int fl,
                         output int cnt, output int nreq, output logic [31:0] a1);
        int   reqc;
        int   guard;
        logic prev;
        reqc = 0; guard = 0; prev = 1'b0; cnt = 0; nreq = 0; a1 = 32'h0;
        forever begin
            #1;
            if (!stall) break;
            cnt++;
            if (mem_req) begin
                if (!prev) begin
                    nreq++;
                    reqc = 0;
                    if (nreq == 1) a1 = mem_addr;
                end
                reqc++;
            end
            prev = mem_req;
            if (mem_req && nreq == 1 && redir != 0 && reqc == redir) pc_in = npc;
            if (mem_req && nreq == 1 && fl != 0 && reqc == fl) flush = 1'b1;
            if (mem_req && reqc == n) begin
                mem_ack   = 1'b1;
                mem_rdata = line_of(mem_addr);
            end
            @(posedge clk);
            #3;
            mem_ack = 1'b0;
            flush   = 1'b0;
            guard++;
            if (guard > 60) begin
                compared++;
                failed++;
                $display("FAIL serve_timeout: still stalled after %0d cycles, expected a hit", guard);
                break;
            end
        end
    endtask

    initial begin
        int          cnt, nreq;
        logic [31:0] a1;
        logic [31:0] hp [3];
        logic [31:0] hv [3];
        hp[0] = 32'h1004; hp[1] = 32'h1008; hp[2] = 32'h100C;
        hv[0] = 32'h22222222; hv[1] = 32'h33333333; hv[2] = 32'h44444444;

        reset = 1'b1; pc_in = 32'h1000; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        tick();
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_instr", instr, 32'h0);
        tick();
        reset = 1'b0;

        // Cold miss, N=3, then the other words of the line.
        serve(3, 0, 32'h0, 0, cnt, nreq, a1);
        check("cold_stall_cycles", 32'(cnt), 32'd4);
        check("cold_mem_addr", a1, 32'h1000);
        check("cold_instr", instr, 32'h11111111);
        for (int i = 0; i < 3; i++) begin
            tick();
            pc_in = hp[i];
            #1;
            check("hit_instr", instr, hv[i]);
            check("hit_stall", 32'(stall), 32'd0);
        end

        // Conflict miss on the same slot, then the evicted line misses again (N=1).
        tick();
        pc_in = 32'h1040;
        serve(2, 0, 32'h0, 0, cnt, nreq, a1);
        check("conf_stall_cycles", 32'(cnt), 32'd3);
        check("conf_mem_addr", a1, 32'h1040);
        check("conf_instr", instr, 32'hAB001040);
        tick();
        pc_in = 32'h1000;
        serve(1, 0, 32'h0, 0, cnt, nreq, a1);
        check("n1_stall_cycles", 32'(cnt), 32'd2);
        check("n1_mem_addr", a1, 32'h1000);
        check("n1_nreq", 32'(nreq), 32'd1);
        check("n1_instr", instr, 32'h11111111);

        // Flush while idle forces a miss on a resident line.
        tick();
        flush = 1'b1;
        #1;
        check("flush_lookup_stall", 32'(stall), 32'd1);
        check("flush_lookup_valid", 32'(instr_valid), 32'd0);
        tick();
        check("flush_lookup_noreq", 32'(mem_req), 32'd0);
        flush = 1'b0;

        // Redirect during the refill of 0x1000 to 0x2010.
        serve(3, 2, 32'h2010, 0, cnt, nreq, a1);
        check("redir_first_addr", a1, 32'h1000);
        check("redir_nreq", 32'(nreq), 32'd2);
        check("redir_instr", instr, 32'hAB002010);
        tick();
        pc_in = 32'h1000;
        #1;
        check("redir_old_hit", 32'(instr_valid), 32'd1);
        check("redir_old_instr", instr, 32'h11111111);
        tick();
        #1;
        check("redir_old_noreq", 32'(mem_req), 32'd0);

        // Flush in WAIT drops the returning line; same-cycle flush+ack too.
        tick();
        pc_in = 32'h1010;
        serve(3, 0, 32'h0, 2, cnt, nreq, a1);
        check("drop_nreq", 32'(nreq), 32'd2);
        check("drop_instr", instr, 32'hAB001010);
        tick();
        pc_in = 32'h1020;
        serve(2, 0, 32'h0, 2, cnt, nreq, a1);
        check("flushack_nreq", 32'(nreq), 32'd2);
        check("flushack_instr", instr, 32'hAB001020);
        tick();
        pc_in = 32'h1010;
        #1;
        check("flushack_cleared", 32'(stall), 32'd1);
        tick();
        pc_in = 32'h1000;
        serve(2, 0, 32'h0, 0, cnt, nreq, a1);
        check("refill_1000_instr", instr, 32'h11111111);

        // Reset during WAIT, with a stray ack under reset and one in LOOKUP.
        tick();
        pc_in = 32'h3000;
        for (int g = 0; g < 10; g++) begin
            #1;
            if (mem_req) break;
            tick();
        end
        check("rstw_req_before", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        check("rstw_req_dropped", 32'(mem_req), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = line_of(32'h3000);
        tick();
        mem_ack = 1'b0;
        reset   = 1'b0;
        pc_in   = 32'h1000;
        mem_ack = 1'b1;
        #1;
        check("rstw_line_invalid", 32'(stall), 32'd1);
        check("rstw_no_hit", 32'(instr_valid), 32'd0);
        tick();
        mem_ack = 1'b0;
        #1;
        check("rstw_lookup_req", 32'(mem_req), 32'd1);
        check("rstw_lookup_addr", mem_addr, 32'h1000);
        tick();
        serve(1, 0, 32'h0, 0, cnt, nreq, a1);
        check("rstw_refill_instr", instr, 32'h11111111);

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/m_icache.md
# m_icache

Direct-mapped, read-only instruction cache between the program counter and instruction memory. It takes the current fetch address, returns the 32-bit instruction on a hit in the same cycle, and on a miss refills one line from memory through a req/ack handshake. While the miss is outstanding it raises `stall`, which freezes the PC. It is the responder side of the PC fetch interface and owns the only path from the fetch stage to memory.

## Interface

Parameters:
- `LINES`, default 4: number of cache lines (power of 2, ≥2).
- `LINE_BYTES`, fixed at 16: four 32-bit words per line; memory returns one full line per transfer.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `pc_in` in 32: fetch address from the PC; word-aligned, bits [1:0] ignored.
- `flush` in 1: invalidate all lines.
- `instr` out 32: fetched instruction; valid only when `instr_valid`=1.
- `instr_valid` out 1: hit this cycle.
- `stall` out 1: fetch not serviced this cycle; wired to the PC stall input.
- `mem_req` out 1: line refill request, registered.
- `mem_addr` out 32: line-aligned refill address, registered, bits [3:0]=0.
- `mem_ack` in 1: one-cycle pulse; `mem_rdata` is valid in that cycle.
- `mem_rdata` in 128: refill line; word 0 in [31:0], word 3 in [127:96].

## Operation

- Address split, with IW = log2(LINES):
  - offset = `pc_in`[3:0]
  - word = `pc_in`[3:2]
  - index = `pc_in`[3+IW:4]
  - tag = `pc_in`[31:4+IW]
- Storage per line: valid bit, tag, 128-bit data.
- States:
  - `LOOKUP`
    - hit = valid[index] && tag match.
    - Hit: `instr` = data[index] word `word`, `instr_valid`=1, `stall`=0.
    - Miss: `stall`=1, `instr_valid`=0. Latch `mem_addr` = {`pc_in`[31:4],4'b0}, set `mem_req`=1, go to `WAIT`.
  - `WAIT`
    - `stall`=1 and `instr_valid`=0 every cycle.
    - `mem_req` stays 1 until the cycle `mem_ack`=1.
    - On `mem_ack`: install `mem_rdata`, tag, and valid at the latched index (unless `drop` is set), clear `mem_req`, go to `LOOKUP`.
- Refill installs at the latched address, not the current `pc_in`. If `pc_in` changed during the miss (the exception path overrides stall in the PC), the refilled line is still installed and `LOOKUP` re-evaluates the new `pc_in`.
- `flush`:
  - Clears all valid bits at the next edge.
  - In `LOOKUP`, it forces a miss for that cycle: `stall`=1, `instr_valid`=0, no request issued that cycle.
  - In `WAIT`, it sets an internal `drop` flag. The outstanding `mem_ack` is still awaited, but the data is not installed. `drop` clears on that ack.
- `mem_ack` outside `WAIT` is ignored.
- No write path; cache contents change only on refill and flush.

## Timing

- Reset values:
  - state `LOOKUP`, all valid=0, `drop`=0
  - `mem_req`=0, `mem_addr`=0
  - `instr_valid`=0, `stall`=1 while the PC's reset address misses
  - `instr` = 0 when not valid
- Hit latency: 0 cycles; `instr`, `instr_valid`, and `stall` are combinational from `pc_in` and array state.
- Miss penalty: with memory acking N cycles after `mem_req` rises (N≥1), `stall`=1 for N+1 cycles (detect cycle + N), and the hit appears in the cycle after ack.
- `mem_req` rises the cycle after miss detection and falls the cycle after `mem_ack`. Exactly one request is outstanding at any time.
- Asynchronous `reset` mid-`WAIT`:
  - immediately drops `mem_req` and invalidates all lines
  - returns to `LOOKUP`
  - a late `mem_ack` is ignored
- `flush` and `mem_ack` in the same `WAIT` cycle: data is discarded and all lines are invalid afterwards.

## Structure

- Shared package `icache_pkg`:
  - `LINE_BYTES`, `WORDS_PER_LINE`=4
  - state enum {`LOOKUP`, `WAIT`}
  - reset PC constant 32'h00001000 (also used by the PC)
  - field-extract helpers for index, tag, and word.
- One natural sub-module, `m_icache_array`:
  - valid/tag/data storage
  - combinational read port indexed by `pc_in`
  - one synchronous write port
  - synchronous invalidate-all plus asynchronous reset clear.
- `m_icache` holds the FSM, the latched refill address, and `drop`.

## Test plan

1. **Cold miss, then hits.**
   - After reset, `pc_in`=0x1000, memory acks after 3 cycles with rdata=0x…4444_3333_2222_1111.
   - Expect: `stall`=1 for 4 cycles, `mem_addr`=0x1000, then `instr`=0x11111111.
   - Then `pc_in`=0x1004/0x1008/0x100C give 0x22222222/0x33333333/0x44444444 with `stall`=0.
2. **Conflict miss (LINES=4).**
   - Fill line for 0x1000, then access 0x1040 (same index, different tag).
   - Expect: miss, refill at `mem_addr`=0x1040.
   - Re-access 0x1000: misses again.
3. **Redirect during miss.**
   - Miss on 0x1000; before ack, `pc_in` becomes 0x2000.
   - Expect: line 0x1000 installed, then `LOOKUP` misses on 0x2000 and requests `mem_addr`=0x2000.
   - Later 0x1000 hits with no request.
4. **Flush.**
   - Flush with `flush` idle, then access 0x1000: expect a miss.
   - Flush asserted in `WAIT`: ack completes, data not installed, next cycle 0x1000 re-requests.
5. **Reset mid-refill.**
   - Assert `reset` during `WAIT`.
   - Expect: `mem_req`=0 immediately; a subsequent stray `mem_ack` leaves all lines invalid and the state in `LOOKUP`.
6. **Back-to-back ack timing.**
   - Memory acks in the first `mem_req` cycle (N=1).
   - Expect: `stall`=1 for exactly 2 cycles and a hit on the 3rd.
